// File: rtl/ultrasonic_scan_scheduler.sv
// rtl/ultrasonic_scan_scheduler.sv - round-robin scheduler sharing one ranging engine among HC-SR04 sensors
// Triggers each enabled sensor in turn, times its echo in us and publishes a tagged distance in cm.
module ultrasonic_scan_scheduler #(
  parameter int N_SENSORS  = 4,
  parameter int CLK_PER_US = 100,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int HOLDOFF_US = 10000,
  parameter int US_PER_CM  = 58,
  localparam int IW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
  input  logic                 clk_100MHz,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] sensor_mask,
  input  logic [N_SENSORS-1:0] echo_in,
  output logic [N_SENSORS-1:0] trig_out,
  output logic                 dist_valid,
  output logic [IW-1:0]        dist_sensor_id,
  output logic [10:0]          dist_cm,
  output logic                 timeout_flag,
  output logic                 busy
);

  localparam int PSW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int CMW = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
  localparam logic [PSW-1:0] PS_LAST   = PSW'(CLK_PER_US - 1);
  localparam logic [CMW-1:0] CM_LAST   = CMW'(US_PER_CM - 1);
  localparam logic [15:0]    TRIG_LAST = 16'(TRIG_US - 1);
  localparam logic [15:0]    TO_LAST   = 16'(TIMEOUT_US - 1);
  localparam logic [15:0]    HO_LAST   = 16'(HOLDOFF_US - 1);
  localparam logic [10:0]    CM_MAX    = 11'h7FE;
  localparam logic [10:0]    CM_NONE   = 11'h7FF;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_TRIG, S_WAIT_RISE, S_MEASURE, S_DONE, S_HOLDOFF
  } state_t;

  state_t state, next_state;

  logic [IW-1:0]        pointer, sel_ptr, sel_idx, ptr_next;
  logic                 sel_found;
  logic [N_SENSORS-1:0] echo_meta, echo_sync;
  logic                 echo_cur, seen_low, rise, fall;
  logic                 timed_out, to_next;
  logic [PSW-1:0]       presc;
  logic [15:0]          us_cnt;
  logic [CMW-1:0]       cm_sub;
  logic [10:0]          cm_cnt;
  logic                 us_tick, state_change;

  assign echo_cur     = echo_sync[pointer];
  assign rise         = seen_low & echo_cur;
  assign fall         = ~echo_cur;
  assign us_tick      = (presc == PS_LAST);
  assign state_change = (next_state != state);
  assign busy         = (state != S_IDLE);

  // Next set mask bit strictly after the pointer, wrapping; a lone bit reselects itself.
  always_comb begin
    sel_ptr   = pointer;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 1; i <= N_SENSORS; i++) begin
      sel_idx = IW'((int'(pointer) + i) % N_SENSORS);
      if (!sel_found && sensor_mask[sel_idx]) begin
        sel_ptr   = sel_idx;
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    to_next    = 1'b0;
    unique case (state)
      S_IDLE:      if (enable && (sensor_mask != '0)) next_state = S_SELECT;
      S_SELECT:    next_state = sel_found ? S_TRIG : S_IDLE;
      S_TRIG:      if (us_tick && us_cnt == TRIG_LAST) next_state = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (rise) next_state = S_MEASURE;
        else if (us_tick && us_cnt == TO_LAST) begin
          next_state = S_DONE;
          to_next    = 1'b1;
        end
      end
      S_MEASURE: begin
        // A falling edge outranks a timeout landing in the same cycle.
        if (fall) next_state = S_DONE;
        else if (us_tick && us_cnt == TO_LAST) begin
          next_state = S_DONE;
          to_next    = 1'b1;
        end
      end
      S_DONE:      next_state = S_HOLDOFF;
      S_HOLDOFF:   if (us_tick && us_cnt == HO_LAST) next_state = enable ? S_SELECT : S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  assign ptr_next = (state == S_SELECT && sel_found) ? sel_ptr : pointer;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pointer   <= IW'(N_SENSORS - 1);
      echo_meta <= '0;
      echo_sync <= '0;
    end else begin
      state     <= next_state;
      pointer   <= ptr_next;
      echo_meta <= echo_in;
      echo_sync <= echo_meta;
    end
  end

  // Shared microsecond time base, restarted on every state entry.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      us_cnt    <= '0;
      cm_sub    <= '0;
      cm_cnt    <= '0;
      seen_low  <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      if (state_change) begin
        presc  <= '0;
        us_cnt <= '0;
      end else if (us_tick) begin
        presc  <= '0;
        us_cnt <= us_cnt + 16'd1;
      end else begin
        presc  <= presc + PSW'(1);
      end

      if (state != S_MEASURE && next_state == S_MEASURE) begin
        cm_sub <= '0;
        cm_cnt <= '0;
      end else if (state == S_MEASURE && us_tick) begin
        if (cm_sub == CM_LAST) begin
          cm_sub <= '0;
          if (cm_cnt != CM_MAX) cm_cnt <= cm_cnt + 11'd1;
        end else begin
          cm_sub <= cm_sub + CMW'(1);
        end
      end

      // An echo already high on entry must go low before a rise counts.
      if (state_change) seen_low <= 1'b0;
      else if (state == S_WAIT_RISE && !echo_cur) seen_low <= 1'b1;

      if (state_change && next_state == S_DONE) timed_out <= to_next;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      trig_out       <= '0;
      dist_valid     <= 1'b0;
      dist_sensor_id <= '0;
      dist_cm        <= '0;
      timeout_flag   <= 1'b0;
    end else begin
      trig_out   <= (next_state == S_TRIG) ? (N_SENSORS'(1) << ptr_next) : '0;
      dist_valid <= (state == S_DONE);
      if (state == S_DONE) begin
        dist_sensor_id <= pointer;
        dist_cm        <= timed_out ? CM_NONE : cm_cnt;
        timeout_flag   <= timed_out;
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// tb/tb_ultrasonic_scan_scheduler.sv - self-checking bench for ultrasonic_scan_scheduler
// Echo responders per sensor, table vectors, directed corner sequences and a randomized model check.
module tb_ultrasonic_scan_scheduler;
  localparam int N     = 4;
  localparam int CPU   = 2;
  localparam int TRIG  = 10;
  localparam int TO_US = 3000;
  localparam int HO    = 100;
  localparam int UPC   = 58;
  localparam int LIMIT = 20000;

  logic         clk_100MHz = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] sensor_mask;
  logic [N-1:0] echo_in;
  logic [N-1:0] trig_out;
  logic         dist_valid;
  logic [1:0]   dist_sensor_id;
  logic [10:0]  dist_cm;
  logic         timeout_flag;
  logic         busy;

  ultrasonic_scan_scheduler #(
    .N_SENSORS(N), .CLK_PER_US(CPU), .TRIG_US(TRIG),
    .TIMEOUT_US(TO_US), .HOLDOFF_US(HO), .US_PER_CM(UPC)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .enable(enable),
    .sensor_mask(sensor_mask), .echo_in(echo_in), .trig_out(trig_out),
    .dist_valid(dist_valid), .dist_sensor_id(dist_sensor_id), .dist_cm(dist_cm),
    .timeout_flag(timeout_flag), .busy(busy)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, last_fall = 0, run = 0;
  int width_bad = 0, onehot_bad = 0, trig2_seen = 0, strobe_bad = 0;
  bit width_chk = 1'b1, forbid2 = 1'b0, prev_valid = 1'b0;

  // mode 0: no echo, 1: echo after rise us for high us, 2: high during trigger, drop after pre us, then as 1
  int   cfg_mode [N];
  int   cfg_rise [N];
  int   cfg_high [N];
  int   cfg_pre  [N];
  logic echo_q   [N];

  always_comb begin
    echo_in = '0;
    for (int i = 0; i < N; i++) echo_in[i] = echo_q[i];
  end

  always @(posedge clk_100MHz) cyc++;

  always @(negedge clk_100MHz) begin
    if (reset) begin
      run = 0;
      prev_valid = 1'b0;
    end else begin
      if ($countones(trig_out) > 1) onehot_bad++;
      if (forbid2 && trig_out[2]) trig2_seen++;
      if (trig_out != '0) run++;
      else if (run != 0) begin
        last_fall = cyc;
        if (width_chk && run != TRIG * CPU) width_bad++;
        run = 0;
      end
      if (dist_valid && prev_valid) strobe_bad++;
      prev_valid = dist_valid;
    end
  end

  task automatic wait_us(input int us);
    repeat (us * CPU) @(posedge clk_100MHz);
    #1;
  endtask

  task automatic responder(input int s);
    forever begin
      do @(negedge clk_100MHz); while (!trig_out[s]);
      if (cfg_mode[s] == 2) echo_q[s] = 1'b1;
      do @(negedge clk_100MHz); while (trig_out[s]);
      if (cfg_mode[s] == 2) begin
        wait_us(cfg_pre[s]);
        echo_q[s] = 1'b0;
      end
      if (cfg_mode[s] != 0) begin
        wait_us(cfg_rise[s]);
        echo_q[s] = 1'b1;
        wait_us(cfg_high[s]);
        echo_q[s] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int s = 0; s < N; s++) begin
      automatic int k = s;
      fork
        responder(k);
      join_none
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int s, input int mode, input int rise, input int high, input int pre);
    cfg_mode[s] = mode;
    cfg_rise[s] = rise;
    cfg_high[s] = high;
    cfg_pre[s]  = pre;
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge clk_100MHz);
      n++;
    end while (!dist_valid && n < LIMIT);
    ok = dist_valid;
  endtask

  task automatic expect_ping(input string name, input int id, input int cm, input int to);
    bit ok;
    wait_valid(ok);
    if (!ok) check({name, "_valid"}, 0, 1);
    else begin
      check({name, "_id"}, int'(dist_sensor_id), id);
      check({name, "_cm"}, int'(dist_cm), cm);
      check({name, "_timeout"}, int'(timeout_flag), to);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < LIMIT) begin
      @(negedge clk_100MHz);
      n++;
    end
    if (busy) check({name, "_idle"}, 1, 0);
  endtask

  function automatic int next_sensor(input logic [N-1:0] m, input int prev);
    for (int k = 1; k <= N; k++)
      if (((m >> ((prev + k) % N)) & 4'b0001) != 4'b0000) return (prev + k) % N;
    return -1;
  endfunction

  typedef struct {
    int sensor;
    int mode;
    int rise;
    int high;
    int exp_cm;
    int exp_to;
  } vec_t;

  vec_t vecs [7];
  int   rr_id [4];
  int   rr_cm [4];

  initial begin
    bit           ok;
    int           n, lat, prev_id, exp_id, exp_cm, exp_to;
    logic [N-1:0] mask_cur;

    vecs[0] = '{0, 1, 200, 1160, 20, 0};
    vecs[1] = '{0, 1,  50,   57,  0, 0};
    vecs[2] = '{0, 1,  50,   58,  1, 0};
    vecs[3] = '{1, 1,  30,  580, 10, 0};
    vecs[4] = '{2, 1,  20, 2320, 40, 0};
    vecs[5] = '{3, 1,  10, 2999, 51, 0};
    vecs[6] = '{1, 0,   0,    0, 2047, 1};
    rr_id = '{0, 1, 3, 0};
    rr_cm = '{10, 20, 40, 10};

    reset = 1'b1;
    enable = 1'b0;
    sensor_mask = '0;
    for (int s = 0; s < N; s++) begin
      echo_q[s] = 1'b0;
      set_cfg(s, 0, 0, 0, 0);
    end
    repeat (4) @(negedge clk_100MHz);
    check("rst_trig", int'(trig_out), 0);
    check("rst_valid", int'(dist_valid), 0);
    check("rst_id", int'(dist_sensor_id), 0);
    check("rst_cm", int'(dist_cm), 0);
    check("rst_timeout", int'(timeout_flag), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    check("idle_no_enable", int'(busy), 0);

    // round robin over mask 1011 from reset
    set_cfg(0, 1, 20, 580, 0);
    set_cfg(1, 1, 20, 1160, 0);
    set_cfg(2, 1, 20, 580, 0);
    set_cfg(3, 1, 20, 2320, 0);
    forbid2 = 1'b1;
    sensor_mask = 4'b1011;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_ping($sformatf("rr%0d", i), rr_id[i], rr_cm[i], 0);
      if (i == 3) enable = 1'b0;
    end
    forbid2 = 1'b0;
    check("rr_trig2_seen", trig2_seen, 0);
    wait_idle("rr");

    // table vectors, one sensor at a time
    set_cfg(vecs[0].sensor, vecs[0].mode, vecs[0].rise, vecs[0].high, 0);
    sensor_mask = 4'b0001 << vecs[0].sensor;
    enable = 1'b1;
    for (int v = 0; v < 7; v++) begin
      wait_valid(ok);
      if (!ok) check($sformatf("vec%0d_valid", v), 0, 1);
      else begin
        check($sformatf("vec%0d_id", v), int'(dist_sensor_id), vecs[v].sensor);
        check($sformatf("vec%0d_cm", v), int'(dist_cm), vecs[v].exp_cm);
        check($sformatf("vec%0d_timeout", v), int'(timeout_flag), vecs[v].exp_to);
        if (vecs[v].mode == 0) begin
          lat = cyc - last_fall;
          check("rise_timeout_latency",
                (lat >= TO_US * CPU && lat <= TO_US * CPU + 3) ? TO_US * CPU + 1 : lat,
                TO_US * CPU + 1);
        end
      end
      if (v < 6) begin
        set_cfg(vecs[v+1].sensor, vecs[v+1].mode, vecs[v+1].rise, vecs[v+1].high, 0);
        sensor_mask = 4'b0001 << vecs[v+1].sensor;
      end
    end

    // echo stuck high beyond the timeout
    set_cfg(1, 1, 10, 4000, 0);
    expect_ping("stuck_high", 1, 2047, 1);
    enable = 1'b0;
    wait_idle("stuck_high");
    n = 0;
    while (echo_q[1] && n < LIMIT) begin
      @(negedge clk_100MHz);
      n++;
    end

    // echo already high when the rise wait starts
    set_cfg(2, 2, 100, 580, 20);
    sensor_mask = 4'b0100;
    enable = 1'b1;
    expect_ping("prehigh", 2, 10, 0);
    enable = 1'b0;
    wait_idle("prehigh");

    // enable dropped while measuring
    set_cfg(0, 1, 20, 1160, 0);
    sensor_mask = 4'b0001;
    enable = 1'b1;
    n = 0;
    while (!trig_out[0] && n < LIMIT) begin
      @(negedge clk_100MHz);
      n++;
    end
    while (trig_out[0] && n < LIMIT) begin
      @(negedge clk_100MHz);
      n++;
    end
    check("en_drop_trig_seen", int'(n < LIMIT), 1);
    repeat ((20 + 300) * CPU) @(negedge clk_100MHz);
    enable = 1'b0;
    expect_ping("en_drop", 0, 20, 0);
    repeat (HO * CPU + 5) @(negedge clk_100MHz);
    check("en_drop_busy", int'(busy), 0);
    n = 0;
    repeat (400) begin
      @(negedge clk_100MHz);
      if (trig_out != '0) n++;
    end
    check("en_drop_no_trig", n, 0);
    sensor_mask = '0;
    enable = 1'b1;
    n = 0;
    repeat (200) begin
      @(negedge clk_100MHz);
      if (trig_out != '0 || busy) n++;
    end
    check("mask0_stays_idle", n, 0);
    enable = 1'b0;

    // randomized pings against the round-robin model
    prev_id = 0;
    for (int s = 0; s < N; s++)
      set_cfg(s, ($urandom_range(0, 9) == 0) ? 0 : 1, $urandom_range(5, 100), $urandom_range(1, 700), 0);
    mask_cur = 4'($urandom_range(1, 15));
    sensor_mask = mask_cur;
    enable = 1'b1;
    for (int p = 0; p < 10; p++) begin
      exp_id = next_sensor(mask_cur, prev_id);
      exp_to = (cfg_mode[exp_id] == 0 || cfg_high[exp_id] >= TO_US) ? 1 : 0;
      exp_cm = exp_to ? 2047 : cfg_high[exp_id] / UPC;
      expect_ping($sformatf("rand%0d", p), exp_id, exp_cm, exp_to);
      prev_id = exp_id;
      if (p == 9) enable = 1'b0;
      for (int s = 0; s < N; s++)
        set_cfg(s, ($urandom_range(0, 9) == 0) ? 0 : 1, $urandom_range(5, 100), $urandom_range(1, 700), 0);
      mask_cur = 4'($urandom_range(1, 15));
      sensor_mask = mask_cur;
    end
    wait_idle("rand");

    // reset in the middle of a trigger pulse
    for (int s = 0; s < N; s++) set_cfg(s, 1, 5, 58, 0);
    width_chk = 1'b0;
    sensor_mask = 4'b1111;
    enable = 1'b1;
    n = 0;
    while (!trig_out[1] && n < LIMIT) begin
      @(negedge clk_100MHz);
      n++;
    end
    check("rst_mid_trig_seen", int'(trig_out[1]), 1);
    repeat (5) @(negedge clk_100MHz);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_trig_out", int'(trig_out), 0);
    check("rst_mid_busy", int'(busy), 0);
    repeat (3) @(negedge clk_100MHz);
    reset = 1'b0;
    n = 0;
    while (trig_out == '0 && n < LIMIT) begin
      @(negedge clk_100MHz);
      n++;
    end
    check("rst_first_trig", int'(trig_out), 1);
    enable = 1'b0;

    check("trig_width_bad", width_bad, 0);
    check("trig_onehot_bad", onehot_bad, 0);
    check("valid_strobe_bad", strobe_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
